// File: rtl/maquina_fsm_pkg.sv
// Shared types and default unlock code for the keypad lock controller.
package maquina_fsm_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S1     = 3'd1,
      S2     = 3'd2,
      OPEN   = 3'd3,
      ERRCHK = 3'd4,
      PUNISH = 3'd5
   } state_t;

   localparam int KEY_W_DEF = 4;
   localparam int CODE0_DEF = 7;
   localparam int CODE1_DEF = 8;
   localparam int CODE2_DEF = 9;

endpackage

// File: rtl/maquina_fsm.sv
// Keypad lock control FSM: accepts the 7-8-9 code, drives the error counter,
// the penalty timer, the lock actuator and the error indicator.
module maquina_fsm
   import maquina_fsm_pkg::*;
#(
   parameter int             KEY_W = KEY_W_DEF,
   parameter logic [KEY_W-1:0] CODE0 = KEY_W'(CODE0_DEF),
   parameter logic [KEY_W-1:0] CODE1 = KEY_W'(CODE1_DEF),
   parameter logic [KEY_W-1:0] CODE2 = KEY_W'(CODE2_DEF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] tecla,
   input  logic             PUSHED,
   input  logic             LOCKED,
   input  logic             WAITDONE,
   input  logic             ECNT3,
   output logic             CLRCNTR,
   output logic             CLRTIMER,
   output logic             INC,
   output logic             UNLOCK,
   output logic             ERROR
);

   state_t state_q;
   state_t state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs are Mealy; they are forced low while reset is held so a stray
   // key press during reset cannot pulse INC or UNLOCK.
   always_comb begin
      state_d  = state_q;
      CLRCNTR  = 1'b0;
      CLRTIMER = 1'b0;
      INC      = 1'b0;
      UNLOCK   = 1'b0;
      ERROR    = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (PUSHED) begin
                  if (tecla == CODE0) begin
                     state_d = S1;
                  end else begin
                     state_d = ERRCHK;
                     ERROR   = 1'b1;
                     INC     = 1'b1;
                  end
               end
            end
            S1: begin
               if (PUSHED) begin
                  if (tecla == CODE1) begin
                     state_d = S2;
                  end else begin
                     state_d = ERRCHK;
                     ERROR   = 1'b1;
                     INC     = 1'b1;
                  end
               end
            end
            S2: begin
               if (PUSHED) begin
                  if (tecla == CODE2) begin
                     state_d = OPEN;
                     UNLOCK  = 1'b1;
                     CLRCNTR = 1'b1;
                  end else begin
                     state_d = ERRCHK;
                     ERROR   = 1'b1;
                     INC     = 1'b1;
                  end
               end
            end
            OPEN: begin
               UNLOCK = 1'b1;
               if (LOCKED) begin
                  state_d = IDLE;
               end
            end
            // The counter was bumped on the previous edge, so ECNT3 is current here.
            ERRCHK: begin
               if (ECNT3) begin
                  state_d  = PUNISH;
                  CLRTIMER = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            PUNISH: begin
               ERROR = 1'b1;
               if (WAITDONE) begin
                  state_d = IDLE;
                  CLRCNTR = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maquina_fsm.sv
// Self-checking bench for maquina_fsm: drives key/timer/counter events one
// cycle at a time and compares outputs and next state against a scoreboard.
module tb_maquina_fsm;

   logic       clk;
   logic       rst;
   logic [3:0] tecla;
   logic       PUSHED;
   logic       LOCKED;
   logic       WAITDONE;
   logic       ECNT3;
   logic       CLRCNTR;
   logic       CLRTIMER;
   logic       INC;
   logic       UNLOCK;
   logic       ERROR;

   int checkCount = 0;
   int errorCount = 0;

   // Output vector order: {CLRCNTR, CLRTIMER, INC, UNLOCK, ERROR}
   localparam logic [4:0] O_NONE   = 5'b00000;
   localparam logic [4:0] O_ERRINC = 5'b00101;
   localparam logic [4:0] O_OPENNG = 5'b10010;
   localparam logic [4:0] O_UNLOCK = 5'b00010;
   localparam logic [4:0] O_CLRTMR = 5'b01000;
   localparam logic [4:0] O_ERROR  = 5'b00001;
   localparam logic [4:0] O_RELEAS = 5'b10001;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_S1     = 3'd1;
   localparam logic [2:0] ST_S2     = 3'd2;
   localparam logic [2:0] ST_OPEN   = 3'd3;
   localparam logic [2:0] ST_ERRCHK = 3'd4;
   localparam logic [2:0] ST_PUNISH = 3'd5;

   typedef struct packed {
      logic [4:0] outs;
      logic [2:0] st;
   } exp_t;

   exp_t sbQueue[$];

   maquina_fsm dut (
      .clk      (clk),
      .rst      (rst),
      .tecla    (tecla),
      .PUSHED   (PUSHED),
      .LOCKED   (LOCKED),
      .WAITDONE (WAITDONE),
      .ECNT3    (ECNT3),
      .CLRCNTR  (CLRCNTR),
      .CLRTIMER (CLRTIMER),
      .INC      (INC),
      .UNLOCK   (UNLOCK),
      .ERROR    (ERROR)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
      end
   endtask

   // One cycle of stimulus: expectations are queued as the inputs are driven,
   // then popped and compared once the combinational outputs have settled and
   // again after the clock edge for the registered state.
   task automatic applyStimulus(input string tag, input logic p, input logic [3:0] k,
                                input logic lk, input logic wd, input logic e3,
                                input logic [4:0] expOuts, input logic [2:0] expState);
      exp_t e;
      @(negedge clk);
      PUSHED   = p;
      tecla    = k;
      LOCKED   = lk;
      WAITDONE = wd;
      ECNT3    = e3;
      sbQueue.push_back('{outs: expOuts, st: expState});
      #2;
      e = sbQueue.pop_front();
      checkOutput({tag, "_outs"}, {3'b0, CLRCNTR, CLRTIMER, INC, UNLOCK, ERROR}, {3'b0, e.outs});
      @(posedge clk);
      #1;
      checkOutput({tag, "_state"}, {5'b0, 3'(dut.state_q)}, {5'b0, e.st});
   endtask

   task automatic pressKey(input string tag, input logic [3:0] k,
                           input logic [4:0] expOuts, input logic [2:0] expState);
      applyStimulus(tag, 1'b1, k, 1'b0, 1'b0, 1'b0, expOuts, expState);
   endtask

   // Reset asserted mid-cycle must act at once, without waiting for a clock edge.
   task automatic applyReset(input string tag);
      @(negedge clk);
      PUSHED   = 1'b0;
      LOCKED   = 1'b0;
      WAITDONE = 1'b0;
      ECNT3    = 1'b0;
      tecla    = 4'd0;
      #1;
      rst = 1'b1;
      #1;
      checkOutput({tag, "_rst_outs"}, {3'b0, CLRCNTR, CLRTIMER, INC, UNLOCK, ERROR}, 8'd0);
      checkOutput({tag, "_rst_state"}, {5'b0, 3'(dut.state_q)}, {5'b0, ST_IDLE});
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      tecla    = 4'd0;
      PUSHED   = 1'b0;
      LOCKED   = 1'b0;
      WAITDONE = 1'b0;
      ECNT3    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("por_outs", {3'b0, CLRCNTR, CLRTIMER, INC, UNLOCK, ERROR}, 8'd0);
      checkOutput("por_state", {5'b0, 3'(dut.state_q)}, {5'b0, ST_IDLE});
      @(negedge clk);
      rst = 1'b0;

      // Correct code, open, ignored keys and WAITDONE while open, relock.
      applyStimulus("idle_hold", 1'b0, 4'd7, 1'b1, 1'b1, 1'b1, O_NONE, ST_IDLE);
      pressKey("k7", 4'd7, O_NONE, ST_S1);
      applyStimulus("s1_hold", 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, O_NONE, ST_S1);
      pressKey("k8", 4'd8, O_NONE, ST_S2);
      applyStimulus("s2_hold", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_NONE, ST_S2);
      pressKey("k9", 4'd9, O_OPENNG, ST_OPEN);
      pressKey("open_key", 4'd3, O_UNLOCK, ST_OPEN);
      applyStimulus("open_wd", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, O_UNLOCK, ST_OPEN);
      applyStimulus("open_lock", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, O_UNLOCK, ST_IDLE);

      // Wrong second key, counter below three.
      pressKey("k7b", 4'd7, O_NONE, ST_S1);
      pressKey("k5", 4'd5, O_ERRINC, ST_ERRCHK);
      applyStimulus("errchk_ok", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_NONE, ST_IDLE);

      // Wrong third key.
      pressKey("k7c", 4'd7, O_NONE, ST_S1);
      pressKey("k8c", 4'd8, O_NONE, ST_S2);
      pressKey("k1", 4'd1, O_ERRINC, ST_ERRCHK);
      applyStimulus("errchk_ok2", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_NONE, ST_IDLE);

      // Wrong first key with counter at three: punishment, keys ignored, release.
      pressKey("k3", 4'd3, O_ERRINC, ST_ERRCHK);
      applyStimulus("errchk_3", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, O_CLRTMR, ST_PUNISH);
      pressKey("pun_k7", 4'd7, O_ERROR, ST_PUNISH);
      applyStimulus("pun_lock", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, O_ERROR, ST_PUNISH);
      applyStimulus("pun_done", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, O_RELEAS, ST_IDLE);
      pressKey("k7d", 4'd7, O_NONE, ST_S1);
      pressKey("k8d", 4'd8, O_NONE, ST_S2);
      pressKey("k9d", 4'd9, O_OPENNG, ST_OPEN);

      // Reset during OPEN.
      applyReset("in_open");
      applyStimulus("post_rst1", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_NONE, ST_IDLE);

      // Reset during PUNISH.
      pressKey("k0", 4'd0, O_ERRINC, ST_ERRCHK);
      applyStimulus("errchk_3b", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, O_CLRTMR, ST_PUNISH);
      applyReset("in_punish");
      pressKey("k7e", 4'd7, O_NONE, ST_S1);
      pressKey("k7f", 4'd7, O_ERRINC, ST_ERRCHK);
      applyStimulus("errchk_ok3", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_NONE, ST_IDLE);

      if (sbQueue.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbQueue.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
